// File: rtl/fp_issue.sv
// Issue stage for a floating-point execute unit: request FIFO, single in-flight
// operation with a watchdog, one-entry response register and sticky flags.
package fp_issue_pkg;
   typedef enum logic [4:0] {
      FP_FADD = 5'd0, FP_FSUB, FP_FMUL, FP_FDIV, FP_FSQRT, FP_FSGNJ,
      FP_FSGNJN, FP_FSGNJX, FP_FMIN, FP_FMAX, FP_FCMP, FP_FCVT,
      FP_FMADD, FP_FMSUB, FP_FNMADD, FP_FNMSUB
   } fp_operation_type;
endpackage

module fp_issue
   import fp_issue_pkg::*;
#(
   parameter int DEPTH   = 2,
   parameter int TAG_W   = 5,
   parameter int TIMEOUT = 255
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [63:0]      req_data1,
   input  logic [63:0]      req_data2,
   input  logic [63:0]      req_data3,
   input  fp_operation_type req_op,
   input  logic [1:0]       req_fmt,
   input  logic [2:0]       req_rm,
   input  logic [TAG_W-1:0] req_tag,
   output logic             exe_enable,
   output logic [63:0]      exe_data1,
   output logic [63:0]      exe_data2,
   output logic [63:0]      exe_data3,
   output fp_operation_type exe_op,
   output logic [1:0]       exe_fmt,
   output logic [2:0]       exe_rm,
   input  logic [63:0]      exe_result,
   input  logic [4:0]       exe_flags,
   input  logic             exe_ready,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [63:0]      resp_result,
   output logic [4:0]       resp_flags,
   output logic [TAG_W-1:0] resp_tag,
   output logic             resp_err,
   output logic [4:0]       fflags,
   input  logic             fflags_clr,
   input  logic             flush
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [CW-1:0] TMO      = CW'(TIMEOUT);

   typedef struct packed {
      logic [63:0]      data1;
      logic [63:0]      data2;
      logic [63:0]      data3;
      fp_operation_type op;
      logic [1:0]       fmt;
      logic [2:0]       rm;
      logic [TAG_W-1:0] tag;
   } entry_t;

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   entry_t           q_mem [DEPTH];
   entry_t           incoming;
   entry_t           head;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   state_t           state;
   state_t           state_next;
   logic [CW-1:0]    wdog;
   logic [TAG_W-1:0] flight_tag;
   logic             push;
   logic             issue;
   logic             wait_done;
   logic             load;
   logic             load_err;
   logic [TAG_W-1:0] load_tag;

   assign incoming.data1 = req_data1;
   assign incoming.data2 = req_data2;
   assign incoming.data3 = req_data3;
   assign incoming.op    = req_op;
   assign incoming.fmt   = req_fmt;
   assign incoming.rm    = req_rm;
   assign incoming.tag   = req_tag;

   assign head      = q_mem[rd_ptr];
   assign req_ready = (count != FULL_CNT);
   assign push      = req_valid && req_ready && !flush;
   // Only one op may be outstanding, and its response needs a free slot.
   assign issue     = (state == IDLE) && (count != '0) &&
                      (!resp_valid || resp_ready) && !flush;

   // ---- request queue ----
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (issue)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, issue})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push)
         q_mem[wr_ptr] <= incoming;
   end

   // ---- issue FSM ----
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (issue && !exe_ready) state_next = WAIT;
            WAIT:    if (exe_ready || wdog == TMO) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      exe_enable = issue;
      exe_data1  = '0;
      exe_data2  = '0;
      exe_data3  = '0;
      exe_op     = fp_operation_type'('0);
      exe_fmt    = '0;
      exe_rm     = '0;
      if (issue) begin
         exe_data1 = head.data1;
         exe_data2 = head.data2;
         exe_data3 = head.data3;
         exe_op    = head.op;
         exe_fmt   = head.fmt;
         exe_rm    = head.rm;
      end
      wait_done = (state == WAIT) && !flush && (exe_ready || wdog == TMO);
      load      = (issue && exe_ready) || wait_done;
      load_err  = wait_done && !exe_ready;
      load_tag  = issue ? head.tag : flight_tag;
   end

   // ---- watchdog and in-flight tag ----
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         wdog <= '0;
      else if (issue)
         wdog <= '0;
      else if (state == WAIT && wdog != TMO)
         wdog <= wdog + CW'(1);
   end

   always_ff @(posedge clock) begin
      if (issue)
         flight_tag <= head.tag;
   end

   // ---- response register and sticky flags ----
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         resp_valid  <= 1'b0;
         resp_result <= '0;
         resp_flags  <= '0;
         resp_tag    <= '0;
         resp_err    <= 1'b0;
      end else if (flush) begin
         resp_valid <= 1'b0;
      end else if (load) begin
         resp_valid  <= 1'b1;
         resp_result <= load_err ? 64'd0 : exe_result;
         resp_flags  <= load_err ? 5'd0 : exe_flags;
         resp_tag    <= load_tag;
         resp_err    <= load_err;
      end else if (resp_ready) begin
         resp_valid <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         fflags <= '0;
      else if (load && !load_err)
         fflags <= fflags_clr ? exe_flags : (fflags | exe_flags);
      else if (fflags_clr)
         fflags <= '0;
   end

endmodule
